scoreboard_multi: RTL and testbench

Parametrised successor to the two-player single-digit scoreboard. It holds one multi-digit BCD score per player and accepts score events at any cycle, applying them at frame sync. It detects the win condition, then blinks the winner's score until a new game starts. It renders all scores as a 3x5-cell glyph overlay with a registered pixel output, and sits in the pixel pipeline beside the paddle and ball renderers.

---
 rtl/scoreboard_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_scoreboard_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/scoreboard_multi.sv
// Multi-player BCD scoreboard: frame-synchronous score updates, win detection with
// winner blink, and a registered 3x5-cell glyph overlay for the pixel pipeline.
module scoreboard_multi #(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          NUM_DIGITS   = 2,
    parameter int          WIN_SCORE    = 11,
    parameter int          BLINK_FRAMES = 30,
    parameter int          DIGIT_W      = 60,
    parameter int          DIGIT_H      = 100,
    parameter int          DIGIT_GAP    = 20,
    parameter int          X_MARGIN     = 30,
    parameter int          PLAYER_PITCH = 1100,
    parameter int          Y_MARGIN     = 30,
    parameter logic [23:0] COLOR        = 24'hFFFFFF,
    localparam int         WW           = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                                pixel_clk,
    input  logic                                rst_n,
    input  logic                                fsync,
    input  logic signed [11:0]                  hpos,
    input  logic signed [11:0]                  vpos,
    input  logic [NUM_PLAYERS-1:0]              increment_score,
    input  logic                                new_game,
    output logic [2:0][7:0]                     pixel,
    output logic                                active,
    output logic                                game_over,
    output logic [WW-1:0]                       winner,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] score_bcd
);

    localparam int SW = NUM_DIGITS * 4;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        r = {SW{1'b0}};
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r = r | (SW'(4'((v / (10 ** d)) % 10)) << (4 * d));
        end
        return r;
    endfunction

    localparam bit            WIN_EN  = (WIN_SCORE > 0) && (WIN_SCORE < 10 ** NUM_DIGITS);
    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_EN ? WIN_SCORE : 0);
    localparam logic [SW-1:0] MAX_BCD = to_bcd(10 ** NUM_DIGITS - 1);

    // Saturating BCD increment with ripple carry from the least-significant digit.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic [3:0]    nib;
        logic          c;
        r = {SW{1'b0}};
        c = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            nib = 4'(v >> (4 * d));
            if (c && (nib == 4'd9)) begin
                nib = 4'd0;
            end else if (c) begin
                nib = nib + 4'd1;
                c   = 1'b0;
            end else begin
                nib = nib;
            end
            r = r | (SW'(nib) << (4 * d));
        end
        return (v == MAX_BCD) ? v : r;
    endfunction

    function automatic logic [14:0] glyph_rows(input logic [3:0] dig);
        case (dig)
            4'd0:    return 15'b111_101_101_101_111;
            4'd1:    return 15'b001_001_001_001_001;
            4'd2:    return 15'b111_001_111_100_111;
            4'd3:    return 15'b111_001_111_001_111;
            4'd4:    return 15'b101_101_111_001_001;
            4'd5:    return 15'b111_100_111_001_111;
            4'd6:    return 15'b111_100_111_101_111;
            4'd7:    return 15'b111_001_001_001_001;
            4'd8:    return 15'b111_101_111_101_111;
            4'd9:    return 15'b111_101_111_001_111;
            default: return 15'b000_000_000_000_000;
        endcase
    endfunction

    // Screen digit d of player p (d=0 is leftmost, most significant) at pixel (x, y).
    function automatic logic digit_lit(input logic [SW-1:0] s, input int p, input int d,
                                       input int x, input int y);
        int         k;
        int         rx;
        int         ry;
        logic [3:0] dig;
        logic       lz;
        k   = NUM_DIGITS - 1 - d;
        dig = 4'(s >> (4 * k));
        lz  = (k != 0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= k) && (4'(s >> (4 * j)) != 4'd0)) begin
                lz = 1'b0;
            end else begin
                lz = lz;
            end
        end
        rx = x - (X_MARGIN + p * PLAYER_PITCH + d * (DIGIT_W + DIGIT_GAP));
        ry = y - Y_MARGIN;
        if (lz || (x < 0) || (y < 0) || (rx < 0) || (rx >= DIGIT_W) || (ry < 0) || (ry >= DIGIT_H)) begin
            return 1'b0;
        end else begin
            return 1'(glyph_rows(dig) >> (14 - (ry / (DIGIT_H / 5)) * 3 - (rx / (DIGIT_W / 3))));
        end
    endfunction

    typedef enum logic {ST_PLAY = 1'b0, ST_OVER = 1'b1} state_t;

    state_t                             state_r, state_nxt_s;
    logic [NUM_PLAYERS-1:0][SW-1:0]     score_r, score_nxt_s;
    logic [NUM_PLAYERS-1:0]             pend_r, pend_nxt_s;
    logic [WW-1:0]                      winner_r, winner_nxt_s;
    logic                               blink_on_r, blink_on_nxt_s;
    logic [CW-1:0]                      blink_cnt_r, blink_cnt_nxt_s;
    logic                               won_s;
    logic                               hit_s;
    logic                               active_r;
    logic [2:0][7:0]                    pixel_r;

    // Game state register plus the registered pixel outputs.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_r     <= ST_PLAY;
            score_r     <= {NUM_PLAYERS*SW{1'b0}};
            pend_r      <= {NUM_PLAYERS{1'b0}};
            winner_r    <= {WW{1'b0}};
            blink_on_r  <= 1'b1;
            blink_cnt_r <= {CW{1'b0}};
            active_r    <= 1'b0;
            pixel_r     <= 24'h000000;
        end else begin
            state_r     <= state_nxt_s;
            score_r     <= score_nxt_s;
            pend_r      <= pend_nxt_s;
            winner_r    <= winner_nxt_s;
            blink_on_r  <= blink_on_nxt_s;
            blink_cnt_r <= blink_cnt_nxt_s;
            active_r    <= hit_s;
            pixel_r     <= hit_s ? COLOR : 24'h000000;
        end
    end

    // Next-state: new_game wins over everything; scores only move on fsync.
    always_comb begin
        state_nxt_s     = state_r;
        score_nxt_s     = score_r;
        pend_nxt_s      = pend_r | increment_score;
        winner_nxt_s    = winner_r;
        blink_on_nxt_s  = blink_on_r;
        blink_cnt_nxt_s = blink_cnt_r;
        won_s           = 1'b0;
        if (new_game) begin
            state_nxt_s     = ST_PLAY;
            score_nxt_s     = {NUM_PLAYERS*SW{1'b0}};
            pend_nxt_s      = {NUM_PLAYERS{1'b0}};
            blink_on_nxt_s  = 1'b1;
            blink_cnt_nxt_s = {CW{1'b0}};
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (fsync) begin
                        pend_nxt_s = {NUM_PLAYERS{1'b0}};
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            if (pend_r[p] | increment_score[p]) begin
                                score_nxt_s[p] = bcd_inc(score_r[p]);
                                if (WIN_EN && !won_s && (score_nxt_s[p] == WIN_BCD)) begin
                                    won_s        = 1'b1;
                                    winner_nxt_s = WW'(p);
                                end else begin
                                    won_s = won_s;
                                end
                            end else begin
                                score_nxt_s[p] = score_r[p];
                            end
                        end
                        state_nxt_s = won_s ? ST_OVER : ST_PLAY;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    pend_nxt_s = {NUM_PLAYERS{1'b0}};
                    if (fsync && (blink_cnt_r == CW'(BLINK_FRAMES - 1))) begin
                        blink_cnt_nxt_s = {CW{1'b0}};
                        blink_on_nxt_s  = !blink_on_r;
                    end else if (fsync) begin
                        blink_cnt_nxt_s = blink_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        blink_cnt_nxt_s = blink_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_PLAY;
                end
            endcase
        end
    end

    // Glyph hit test: OR of every lit cell; the winner is blanked on blink-off phases.
    always_comb begin
        hit_s = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (!((state_r == ST_OVER) && !blink_on_r && (winner_r == WW'(p))) &&
                    digit_lit(score_r[p], p, d, int'(hpos), int'(vpos))) begin
                    hit_s = 1'b1;
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    assign pixel     = pixel_r;
    assign active    = active_r;
    assign game_over = (state_r == ST_OVER);
    assign winner    = winner_r;
    assign score_bcd = score_r;

endmodule

// File: tb/tb_scoreboard_multi.sv
// Directed self-checking bench for scoreboard_multi: scoring, carry, saturation,
// win/blink, new_game priority, reset, and glyph placement probes.
module tb_scoreboard_multi;

    logic              pixel_clk;
    logic              rst_n;
    logic              fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic [1:0]        increment_score;
    logic [1:0]        inc_b;
    logic              new_game;
    logic [2:0][7:0]   pixel;
    logic              active;
    logic              game_over;
    logic [0:0]        winner;
    logic [15:0]       score_bcd;
    logic [2:0][7:0]   pixel_b;
    logic              active_b;
    logic              game_over_b;
    logic [0:0]        winner_b;
    logic [7:0]        score_bcd_b;

    int n_checks = 0;
    int n_errors = 0;

    scoreboard_multi dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .hpos(hpos), .vpos(vpos),
        .increment_score(increment_score), .new_game(new_game), .pixel(pixel),
        .active(active), .game_over(game_over), .winner(winner), .score_bcd(score_bcd)
    );

    scoreboard_multi #(.NUM_DIGITS(1), .WIN_SCORE(0)) dut_one (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .hpos(hpos), .vpos(vpos),
        .increment_score(inc_b), .new_game(new_game), .pixel(pixel_b),
        .active(active_b), .game_over(game_over_b), .winner(winner_b), .score_bcd(score_bcd_b)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One clock with the given event inputs, then back to idle.
    task automatic drive(input logic f, input logic [1:0] inc, input logic [1:0] incb, input logic ng);
        fsync = f; increment_score = inc; inc_b = incb; new_game = ng;
        tick();
        fsync = 1'b0; increment_score = 2'b00; inc_b = 2'b00; new_game = 1'b0;
    endtask

    task automatic frames(input int n, input logic [1:0] inc, input logic [1:0] incb);
        for (int i = 0; i < n; i++) drive(1'b1, inc, incb, 1'b0);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic exp);
        hpos = 12'(x); vpos = 12'(y);
        tick();
        check_eq(tag, {31'd0, active}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; fsync = 1'b0; increment_score = 2'b00; inc_b = 2'b00; new_game = 1'b0;
        hpos = 12'sd160; vpos = 12'sd40;
        tick(); tick();
        check_eq("rst_score", 32'(score_bcd), 32'h0000);
        check_eq("rst_game_over", 32'(game_over), 32'd0);
        check_eq("rst_winner", 32'(winner), 32'd0);
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_pixel", 32'(pixel), 32'h000000);
        rst_n = 1'b1;
        probe("ls_zero_drawn", 160, 40, 1'b1);
        probe("lead_zero_blank", 60, 40, 1'b0);

        // three separate events in three frames
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 2'b00, 1'b0);
            drive(1'b1, 2'b00, 2'b00, 1'b0);
        end
        check_eq("score_03", 32'(score_bcd[7:0]), 32'h03);
        check_eq("score_all_0003", 32'(score_bcd), 32'h0003);
        probe("p0_d1_lit", 160, 40, 1'b1);
        check_eq("pixel_color", 32'(pixel), 32'hFFFFFF);
        probe("p0_d0_blank", 60, 40, 1'b0);
        probe("edge_in", 169, 129, 1'b1);
        probe("edge_x_out", 170, 40, 1'b0);
        probe("edge_y_out", 160, 130, 1'b0);
        probe("g3_r1c0", 110, 50, 1'b0);
        probe("g3_r1c2", 150, 50, 1'b1);
        probe("neg_hpos", -10, 40, 1'b0);

        // pending collapse and fsync-coincident event
        drive(1'b0, 2'b10, 2'b00, 1'b0);
        drive(1'b0, 2'b10, 2'b00, 1'b0);
        drive(1'b1, 2'b11, 2'b00, 1'b0);
        check_eq("collapse", 32'(score_bcd), 32'h0104);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        check_eq("pend_cleared", 32'(score_bcd), 32'h0104);

        // BCD carry
        frames(5, 2'b01, 2'b00);
        check_eq("score_09", 32'(score_bcd), 32'h0109);
        frames(1, 2'b01, 2'b00);
        check_eq("bcd_carry", 32'(score_bcd), 32'h0110);
        probe("p0_ms1_c2", 70, 40, 1'b1);
        probe("p0_ms1_c0", 30, 40, 1'b0);

        // single-digit saturation
        frames(9, 2'b00, 2'b01);
        check_eq("one_dig_9", 32'(score_bcd_b), 32'h09);
        frames(1, 2'b00, 2'b01);
        check_eq("one_dig_sat", 32'(score_bcd_b), 32'h09);

        // simultaneous win: lowest index reported
        frames(9, 2'b10, 2'b00);
        check_eq("score_1010", 32'(score_bcd), 32'h1010);
        check_eq("not_over_yet", 32'(game_over), 32'd0);
        frames(1, 2'b11, 2'b00);
        check_eq("win_score", 32'(score_bcd), 32'h1111);
        check_eq("win_over", 32'(game_over), 32'd1);
        check_eq("win_winner0", 32'(winner), 32'd0);
        frames(1, 2'b11, 2'b00);
        drive(1'b0, 2'b01, 2'b00, 1'b0);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        check_eq("over_ignores", 32'(score_bcd), 32'h1111);
        probe("blink_on_a", 160, 40, 1'b1);
        frames(27, 2'b00, 2'b00);
        probe("blink_on_29", 160, 40, 1'b1);
        frames(1, 2'b00, 2'b00);
        probe("blink_off_30", 160, 40, 1'b0);
        probe("loser_steady", 1250, 40, 1'b1);
        check_eq("blink_score_kept", 32'(score_bcd), 32'h1111);
        frames(30, 2'b00, 2'b00);
        probe("blink_on_60", 160, 40, 1'b1);

        // new_game dominates fsync and increments
        drive(1'b1, 2'b11, 2'b00, 1'b1);
        check_eq("ng_score", 32'(score_bcd), 32'h0000);
        check_eq("ng_over", 32'(game_over), 32'd0);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        check_eq("ng_no_pend", 32'(score_bcd), 32'h0000);

        // player 1 wins, then reset mid-frame
        frames(11, 2'b10, 2'b00);
        check_eq("p1_win_score", 32'(score_bcd), 32'h1100);
        check_eq("p1_win_over", 32'(game_over), 32'd1);
        check_eq("p1_winner", 32'(winner), 32'd1);
        hpos = 12'sd1250; vpos = 12'sd40;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_score", 32'(score_bcd), 32'h0000);
        check_eq("mid_rst_over", 32'(game_over), 32'd0);
        check_eq("mid_rst_winner", 32'(winner), 32'd0);
        check_eq("mid_rst_active", 32'(active), 32'd0);
        check_eq("mid_rst_pixel", 32'(pixel), 32'h000000);
        tick();
        check_eq("post_rst_zero", 32'(active), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
